// File: rtl/test_axis_rx_checker.sv
// Receive-side checker for the Ethernet loopback test path.
// Validates each frame from the MAC RX AXI-Stream against the fixed test frame
// format. Checks cover the header, sequence continuity, the payload pattern
// and length/tkeep consistency. Saturating statistics and sticky error flags
// are kept for readback. An optional LFSR applies backpressure on tready.
// Only a 64-bit stream is supported.

module test_axis_rx_checker #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int MAX_FRAME_BYTES = 9000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         test_en,
    input  logic                         clr_stat,
    input  logic                         bp_en,
    input  logic [AXIS_DATA_WIDTH-1:0]   rx_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] rx_axis_tkeep,
    input  logic                         rx_axis_tvalid,
    input  logic                         rx_axis_tlast,
    output logic                         rx_axis_tready,
    output logic [31:0]                  frame_cnt,
    output logic [31:0]                  err_frame_cnt,
    output logic [47:0]                  byte_cnt,
    output logic [3:0]                   err_flags,
    output logic                         seq_lock,
    output logic [31:0]                  last_err_seq
);

    localparam logic [15:0] MAGIC     = 16'hA55A;
    localparam logic [15:0] MIN_LEN   = 16'd8;
    localparam logic [15:0] MAX_LEN   = 16'(MAX_FRAME_BYTES);
    localparam logic [15:0] K_MAX     = 16'hFFFF;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_e;

    // Expected tkeep on the final beat for a given L%8.
    function automatic logic [7:0] tail_keep(input logic [2:0] rem);
        tail_keep = (rem == 3'd0) ? 8'hFF : ((8'h01 << rem) - 8'h01);
    endfunction

    state_e      state_q, state_d;
    logic        in_frame_q, in_frame_d;
    logic [31:0] seq_q, seq_d;
    logic [15:0] last_idx_q, last_idx_d;   // N-1 of the current frame
    logic [7:0]  last_keep_q, last_keep_d;
    logic [15:0] k_q, k_d;
    logic        hdr_err_q, hdr_err_d;     // suppresses payload/length checks
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;     // "no tlast at N-1" already flagged
    logic [31:0] exp_seq_q, exp_seq_d;
    logic        seq_lock_q, seq_lock_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] err_frame_cnt_q, err_frame_cnt_d;
    logic [47:0] byte_cnt_q, byte_cnt_d;
    logic [3:0]  err_flags_q, err_flags_d;
    logic [31:0] last_err_seq_q, last_err_seq_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        tready_q, tready_d;

    logic        beat_acc, checking;
    logic [15:0] hdr_magic, hdr_len;
    logic [31:0] hdr_seq;
    logic        hdr_bad;
    logic [63:0] exp_beat;
    logic [7:0]  exp_keep;
    logic        pay_mismatch;
    logic [3:0]  keep_bytes;
    logic [48:0] byte_sum;
    logic        e_hdr, e_seq, e_pay, e_len;
    logic        lock_set, frame_end, frame_bad;
    logic [31:0] end_seq;

    assign beat_acc  = rx_axis_tvalid & tready_q;
    assign checking  = test_en & (state_q != ST_IDLE);
    assign hdr_magic = rx_axis_tdata[63:48];
    assign hdr_len   = rx_axis_tdata[47:32];
    assign hdr_seq   = rx_axis_tdata[31:0];
    assign hdr_bad   = (hdr_magic != MAGIC) || (hdr_len < MIN_LEN) || (hdr_len > MAX_LEN);

    // Frame tracking and per-beat checks: state, header latch, error detection.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        in_frame_d   = in_frame_q;
        seq_d        = seq_q;
        last_idx_d   = last_idx_q;
        last_keep_d  = last_keep_q;
        k_d          = k_q;
        hdr_err_d    = hdr_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        exp_seq_d    = exp_seq_q;
        e_hdr        = 1'b0;
        e_seq        = 1'b0;
        e_pay        = 1'b0;
        e_len        = 1'b0;
        lock_set     = 1'b0;
        frame_end    = 1'b0;
        frame_bad    = 1'b0;
        end_seq      = seq_q;
        exp_beat     = {seq_q, 16'h0000, k_q};
        exp_keep     = (k_q == last_idx_q) ? last_keep_q : 8'hFF;
        pay_mismatch = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rx_axis_tkeep[i] && (rx_axis_tdata[8*i +: 8] != exp_beat[8*i +: 8])) begin
                pay_mismatch = 1'b1;
            end
        end

        // in_frame follows the raw stream in every state so IDLE can find a frame boundary.
        if (beat_acc) begin
            in_frame_d = !rx_axis_tlast;
        end

        if (!test_en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!in_frame_d) state_d = ST_HDR;
                end
                ST_HDR: begin
                    if (beat_acc) begin
                        e_hdr = hdr_bad;
                        if (!hdr_bad) begin
                            e_seq     = seq_lock_q && (hdr_seq != exp_seq_q);
                            e_len     = (rx_axis_tkeep != 8'hFF) || (rx_axis_tlast != (hdr_len == MIN_LEN));
                            lock_set  = 1'b1;
                            exp_seq_d = hdr_seq + 32'd1;
                        end
                        seq_d       = hdr_seq;
                        last_idx_d  = {3'b000, hdr_len[15:3]} + {15'd0, |hdr_len[2:0]} - 16'd1;
                        last_keep_d = tail_keep(hdr_len[2:0]);
                        k_d         = 16'd1;
                        hdr_err_d   = hdr_bad;
                        overrun_d   = !rx_axis_tlast && (hdr_len == MIN_LEN);
                        if (rx_axis_tlast) begin
                            frame_end = 1'b1;
                            frame_bad = e_hdr | e_seq | e_len;
                            end_seq   = hdr_seq;
                        end else begin
                            state_d     = ST_DATA;
                            frame_err_d = e_hdr | e_seq | e_len;
                        end
                    end
                end
                ST_DATA: begin
                    if (beat_acc) begin
                        if (!hdr_err_q) begin
                            e_pay = pay_mismatch;
                            e_len = (rx_axis_tkeep != exp_keep)
                                 || (rx_axis_tlast && (k_q != last_idx_q))
                                 || (!rx_axis_tlast && (k_q == last_idx_q) && !overrun_q);
                        end
                        if (!rx_axis_tlast && (k_q == last_idx_q)) overrun_d = 1'b1;
                        k_d = (k_q == K_MAX) ? k_q : k_q + 16'd1;
                        if (rx_axis_tlast) begin
                            frame_end = 1'b1;
                            frame_bad = frame_err_q | e_pay | e_len;
                            state_d   = ST_HDR;
                        end else begin
                            frame_err_d = frame_err_q | e_pay | e_len;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Statistics: saturating counters, sticky flags; clr_stat overrides any update.
    always_comb begin
        keep_bytes = 4'd0;
        for (int i = 0; i < 8; i++) begin
            keep_bytes = keep_bytes + {3'b000, rx_axis_tkeep[i]};
        end
        byte_sum        = {1'b0, byte_cnt_q} + {45'd0, keep_bytes};
        frame_cnt_d     = frame_cnt_q;
        err_frame_cnt_d = err_frame_cnt_q;
        byte_cnt_d      = byte_cnt_q;
        last_err_seq_d  = last_err_seq_q;
        err_flags_d     = err_flags_q | {e_len, e_pay, e_seq, e_hdr};
        seq_lock_d      = seq_lock_q | lock_set;

        if (beat_acc && checking) begin
            byte_cnt_d = byte_sum[48] ? '1 : byte_sum[47:0];
        end
        if (frame_end) begin
            frame_cnt_d = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + 32'd1;
            if (frame_bad) begin
                err_frame_cnt_d = (err_frame_cnt_q == '1) ? err_frame_cnt_q : err_frame_cnt_q + 32'd1;
                last_err_seq_d  = end_seq;
            end
        end
        if (clr_stat) begin
            frame_cnt_d     = '0;
            err_frame_cnt_d = '0;
            byte_cnt_d      = '0;
            err_flags_d     = '0;
            seq_lock_d      = 1'b0;
            last_err_seq_d  = '0;
        end
    end

    // Backpressure: Fibonacci LFSR (taps 16,14,13,11) drives a registered tready.
    always_comb begin
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        tready_d = !bp_en | lfsr_q[0] | lfsr_q[1];
    end

    // State and statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q         <= ST_IDLE;
            in_frame_q      <= 1'b0;
            seq_q           <= '0;
            last_idx_q      <= '0;
            last_keep_q     <= '0;
            k_q             <= '0;
            hdr_err_q       <= 1'b0;
            frame_err_q     <= 1'b0;
            overrun_q       <= 1'b0;
            exp_seq_q       <= '0;
            seq_lock_q      <= 1'b0;
            frame_cnt_q     <= '0;
            err_frame_cnt_q <= '0;
            byte_cnt_q      <= '0;
            err_flags_q     <= '0;
            last_err_seq_q  <= '0;
            lfsr_q          <= LFSR_SEED;
            tready_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            in_frame_q      <= in_frame_d;
            seq_q           <= seq_d;
            last_idx_q      <= last_idx_d;
            last_keep_q     <= last_keep_d;
            k_q             <= k_d;
            hdr_err_q       <= hdr_err_d;
            frame_err_q     <= frame_err_d;
            overrun_q       <= overrun_d;
            exp_seq_q       <= exp_seq_d;
            seq_lock_q      <= seq_lock_d;
            frame_cnt_q     <= frame_cnt_d;
            err_frame_cnt_q <= err_frame_cnt_d;
            byte_cnt_q      <= byte_cnt_d;
            err_flags_q     <= err_flags_d;
            last_err_seq_q  <= last_err_seq_d;
            lfsr_q          <= lfsr_d;
            tready_q        <= tready_d;
        end
    end

    assign rx_axis_tready = tready_q;
    assign frame_cnt      = frame_cnt_q;
    assign err_frame_cnt  = err_frame_cnt_q;
    assign byte_cnt       = byte_cnt_q;
    assign err_flags      = err_flags_q;
    assign seq_lock       = seq_lock_q;
    assign last_err_seq   = last_err_seq_q;

endmodule

// File: tb/tb_test_axis_rx_checker.sv
// Bench for test_axis_rx_checker: frames are built from the test frame format,
// the expected statistics snapshot for each counted frame is queued when the
// frame is sent and compared when frame_cnt advances.

module tb_test_axis_rx_checker;

    logic        clk = 1'b0;
    logic        rst, test_en, clr_stat, bp_en;
    logic [63:0] rx_axis_tdata;
    logic [7:0]  rx_axis_tkeep;
    logic        rx_axis_tvalid, rx_axis_tlast, rx_axis_tready;
    logic [31:0] frame_cnt, err_frame_cnt, last_err_seq;
    logic [47:0] byte_cnt;
    logic [3:0]  err_flags;
    logic        seq_lock;

    always #5 clk = ~clk;

    test_axis_rx_checker #(.AXIS_DATA_WIDTH(64), .MAX_FRAME_BYTES(9000)) dut (
        .clk            (clk),
        .rst            (rst),
        .test_en        (test_en),
        .clr_stat       (clr_stat),
        .bp_en          (bp_en),
        .rx_axis_tdata  (rx_axis_tdata),
        .rx_axis_tkeep  (rx_axis_tkeep),
        .rx_axis_tvalid (rx_axis_tvalid),
        .rx_axis_tlast  (rx_axis_tlast),
        .rx_axis_tready (rx_axis_tready),
        .frame_cnt      (frame_cnt),
        .err_frame_cnt  (err_frame_cnt),
        .byte_cnt       (byte_cnt),
        .err_flags      (err_flags),
        .seq_lock       (seq_lock),
        .last_err_seq   (last_err_seq)
    );

    typedef struct {
        logic [31:0] fc;
        logic [31:0] efc;
        logic [47:0] bc;
        logic [3:0]  fl;
        logic [31:0] les;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Model of the statistics, driven by the intended outcome of each frame.
    logic [31:0] m_fc, m_efc, m_les;
    logic [47:0] m_bc;
    logic [3:0]  m_fl;
    logic [31:0] prev_fc;
    bit          meas = 1'b0;
    int unsigned meas_cyc = 0, meas_rdy = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_fc = '0; m_efc = '0; m_les = '0; m_bc = '0; m_fl = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold one beat until accepted; tready seen at the negedge is what the next posedge samples.
    task automatic drive_beat(input logic [63:0] data, input logic [7:0] keep, input logic last);
        bit done = 1'b0;
        int waited = 0;
        rx_axis_tdata  = data;
        rx_axis_tkeep  = keep;
        rx_axis_tlast  = last;
        rx_axis_tvalid = 1'b1;
        while (!done) begin
            done = rx_axis_tready;
            @(negedge clk);
            if (!done) begin
                waited++;
                if (waited > 200) begin
                    check("tready_timeout", 64'd0, 64'd1);
                    done = 1'b1;
                end
            end
        end
    endtask

    // Send one frame. keep_ovr!=0 replaces the final tkeep; bad_beat flips byte 2 of that beat;
    // tog_beat changes test_en before that beat; clr_last pulses clr_stat with the tlast beat.
    task automatic send_frame(input logic [31:0] seq, input int len, input logic [15:0] magic,
                              input logic [7:0] keep_ovr, input int bad_beat, input logic [3:0] mask,
                              input bit push, input int tog_beat, input bit tog_val, input bit clr_last);
        int          n;
        logic [7:0]  lk;
        logic [63:0] data;
        logic [7:0]  keep;
        logic [31:0] bidx;
        n  = (len + 7) / 8;
        if (n < 1) n = 1;
        lk = (len % 8 == 0) ? 8'hFF : 8'((9'd1 << (len % 8)) - 9'd1);
        if (keep_ovr != 8'h00) lk = keep_ovr;
        if (n == 1) lk = 8'hFF;
        if (push) begin
            m_fc = m_fc + 32'd1;
            m_bc = m_bc + 48'(8 * (n - 1) + $countones(lk));
            if (mask != 4'h0) begin
                m_efc = m_efc + 32'd1;
                m_les = seq;
            end
            m_fl = m_fl | mask;
            sb.push_back('{m_fc, m_efc, m_bc, m_fl, m_les});
        end
        for (int b = 0; b < n; b++) begin
            if (b == tog_beat) test_en = tog_val;
            bidx = 32'(b);
            data = (b == 0) ? {magic, 16'(len), seq} : {seq, bidx};
            keep = (b == n - 1) ? lk : 8'hFF;
            if (b == bad_beat) data[23:16] = ~data[23:16];
            if (b == n - 1 && clr_last) clr_stat = 1'b1;
            drive_beat(data, keep, (b == n - 1));
            clr_stat = 1'b0;
        end
        rx_axis_tvalid = 1'b0;
        rx_axis_tlast  = 1'b0;
    endtask

    task automatic good_frame(input logic [31:0] seq, input int len);
        send_frame(seq, len, 16'hA55A, 8'h00, -1, 4'h0, 1'b1, -1, 1'b0, 1'b0);
    endtask

    task automatic check_stats(input string pfx);
        check({pfx, "_frame_cnt"},     64'(frame_cnt),     64'(m_fc));
        check({pfx, "_err_frame_cnt"}, 64'(err_frame_cnt), 64'(m_efc));
        check({pfx, "_byte_cnt"},      64'(byte_cnt),      64'(m_bc));
        check({pfx, "_err_flags"},     64'(err_flags),     64'(m_fl));
        check({pfx, "_last_err_seq"},  64'(last_err_seq),  64'(m_les));
    endtask

    task automatic clr_pulse();
        clr_stat = 1'b1;
        @(negedge clk);
        clr_stat = 1'b0;
        model_clear();
    endtask

    // Scoreboard: each frame_cnt step pops the snapshot queued when that frame was sent.
    always @(negedge clk) begin
        if (rst) begin
            prev_fc = '0;
        end else begin
            if (frame_cnt == prev_fc + 32'd1) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_frame", 64'(frame_cnt), 64'(prev_fc));
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_frame_cnt",     64'(frame_cnt),     64'(mon_e.fc));
                    check("sb_err_frame_cnt", 64'(err_frame_cnt), 64'(mon_e.efc));
                    check("sb_byte_cnt",      64'(byte_cnt),      64'(mon_e.bc));
                    check("sb_err_flags",     64'(err_flags),     64'(mon_e.fl));
                    check("sb_last_err_seq",  64'(last_err_seq),  64'(mon_e.les));
                end
            end
            prev_fc = frame_cnt;
        end
    end

    // tready duty measurement during the backpressure run.
    always @(negedge clk) begin
        if (meas) begin
            meas_cyc++;
            if (rx_axis_tready) meas_rdy++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int wait_cyc;
        rst = 1'b1; test_en = 1'b1; clr_stat = 1'b0; bp_en = 1'b0;
        rx_axis_tdata = '0; rx_axis_tkeep = '0; rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0;
        model_clear();
        idle(3);
        check("rst_tready",        64'(rx_axis_tready), 64'd0);
        check("rst_frame_cnt",     64'(frame_cnt),      64'd0);
        check("rst_err_frame_cnt", 64'(err_frame_cnt),  64'd0);
        check("rst_byte_cnt",      64'(byte_cnt),       64'd0);
        check("rst_err_flags",     64'(err_flags),      64'd0);
        check("rst_seq_lock",      64'(seq_lock),       64'd0);
        check("rst_last_err_seq",  64'(last_err_seq),   64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("tready_after_rst", 64'(rx_axis_tready), 64'd1);
        idle(2);

        // Three good 64-byte frames.
        good_frame(32'd5, 64);
        good_frame(32'd6, 64);
        good_frame(32'd7, 64);
        idle(2);
        check("p1_frame_cnt", 64'(frame_cnt),     64'd3);
        check("p1_err_cnt",   64'(err_frame_cnt), 64'd0);
        check("p1_byte_cnt",  64'(byte_cnt),      64'd192);
        check("p1_err_flags", 64'(err_flags),     64'd0);
        check("p1_seq_lock",  64'(seq_lock),      64'd1);

        // L=61: correct tail keep, then a wrong tail keep.
        good_frame(32'd8, 61);
        send_frame(32'd9, 61, 16'hA55A, 8'h3F, -1, 4'h8, 1'b1, -1, 1'b0, 1'b0);
        idle(2);
        check("len_err_cnt", 64'(err_frame_cnt), 64'd1);
        check_stats("len");

        // Sequence gap.
        good_frame(32'd10, 64);
        good_frame(32'd11, 64);
        send_frame(32'd13, 64, 16'hA55A, 8'h00, -1, 4'h2, 1'b1, -1, 1'b0, 1'b0);
        idle(2);
        check("seq_last_err_seq", 64'(last_err_seq), 64'd13);
        check_stats("seq");

        // Clear, then sequence wrap.
        clr_pulse();
        idle(1);
        check_stats("clr");
        check("clr_seq_lock", 64'(seq_lock), 64'd0);
        good_frame(32'hFFFF_FFFF, 64);
        good_frame(32'h0000_0000, 64);
        idle(2);
        check("wrap_err_cnt", 64'(err_frame_cnt), 64'd0);
        check_stats("wrap");

        // Payload corruption, bad magic, L=8 single beat, L=7 illegal.
        send_frame(32'd1, 64, 16'hA55A, 8'h00, 3, 4'h4, 1'b1, -1, 1'b0, 1'b0);
        send_frame(32'd2, 64, 16'hA55B, 8'h00, -1, 4'h1, 1'b1, -1, 1'b0, 1'b0);
        good_frame(32'd2, 64);
        good_frame(32'd3, 8);
        send_frame(32'd4, 7, 16'hA55A, 8'h00, -1, 4'h1, 1'b1, -1, 1'b0, 1'b0);
        good_frame(32'd4, 64);
        idle(2);
        check_stats("hdr");

        // Raise test_en mid-frame: partial frame ignored, next frame checked.
        test_en = 1'b0;
        idle(3);
        send_frame(32'd100, 64, 16'hA55A, 8'h00, -1, 4'h0, 1'b0, 3, 1'b1, 1'b0);
        idle(3);
        good_frame(32'd5, 64);
        idle(2);
        check_stats("raise");

        // Drop test_en mid-frame: no count update, only the three checked beats counted.
        send_frame(32'd6, 64, 16'hA55A, 8'h00, -1, 4'h0, 1'b0, 3, 1'b0, 1'b0);
        m_bc = m_bc + 48'd24;
        idle(3);
        check_stats("drop");
        test_en = 1'b1;
        idle(3);
        good_frame(32'd7, 64);
        idle(2);
        check_stats("after_drop");

        // Backpressure run.
        clr_pulse();
        bp_en = 1'b1;
        idle(2);
        meas = 1'b1;
        for (int i = 0; i < 1000; i++) good_frame(32'd2000 + 32'(i), 64);
        meas = 1'b0;
        idle(3);
        check("bp_frame_cnt", 64'(frame_cnt),     64'd1000);
        check("bp_err_cnt",   64'(err_frame_cnt), 64'd0);
        check("bp_err_flags", 64'(err_flags),     64'd0);
        check("bp_duty_in_70_80",
              64'((meas_rdy * 100 >= meas_cyc * 70) && (meas_rdy * 100 <= meas_cyc * 80)), 64'd1);

        // clr_stat together with an errored tlast beat: clear wins.
        bp_en = 1'b0;
        idle(3);
        send_frame(32'd5000, 64, 16'hA55A, 8'h00, 7, 4'h0, 1'b0, -1, 1'b0, 1'b1);
        model_clear();
        idle(2);
        check_stats("clr_tlast");
        check("clr_tlast_seq_lock", 64'(seq_lock), 64'd0);

        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/test_axis_rx_checker.md
# test_axis_rx_checker

Receive-side checker for the Ethernet loopback test path. It consumes frames from the MAC's RX AXI-Stream port in the coreclk domain and validates each frame against the fixed test frame format. It checks the header, sequence continuity, payload pattern and length/tkeep consistency, and keeps saturating statistics for readback. It can optionally apply pseudo-random backpressure on tready.

## Interface
- AXIS_DATA_WIDTH, 64, stream width; only 64 is supported
- MAX_FRAME_BYTES, 9000, largest legal length field value
- clk  in  1  core clock (coreclk)
- rst  in  1  reset; one clock, reset is synchronous and active-high
- test_en  in  1  enable checking; when low, frames are drained and discarded
- clr_stat  in  1  one-cycle pulse; clears counters, flags and sequence lock
- bp_en  in  1  enable pseudo-random tready backpressure
- rx_axis_tdata  in  64  stream data
- rx_axis_tkeep  in  8  byte enables; bit i covers byte [8i+7:8i]
- rx_axis_tvalid  in  1  stream valid
- rx_axis_tlast  in  1  end of frame
- rx_axis_tready  out  1  stream ready
- frame_cnt  out  32  frames completed while checking
- err_frame_cnt  out  32  frames with at least one error
- byte_cnt  out  48  accepted bytes while checking (sum of popcount(tkeep))
- err_flags  out  4  sticky flags: [0] header, [1] sequence, [2] payload, [3] length/tkeep
- seq_lock  out  1  a first good header has been seen since reset or clear
- last_err_seq  out  32  sequence field of the most recent errored frame

## Operation
**Frame format**
- Beat 0 is the header: [63:48] must be 16'hA55A; [47:32] is L, the length in bytes including the header; [31:0] is seq.
- Beat count N = ceil(L/8). Legal L is 8..MAX_FRAME_BYTES.
- Beat k, for 1 <= k <= N-1, carries {seq, k[31:0]}. Only bytes enabled by tkeep are compared.
- tkeep must be 8'hFF on every beat except beat N-1.
- On beat N-1, tkeep must be 8'hFF when L%8==0, otherwise (1<<(L%8))-1.

**States**
- IDLE: entered from reset, and immediately whenever test_en is low, including mid-frame (the current frame is aborted with no count update).
  - Beats are accepted and discarded.
  - An in_frame bit is set on an accepted non-last beat and cleared on an accepted last beat.
  - Moves to HDR when test_en=1 and in_frame=0, so a partially seen frame is never checked.
- HDR: on an accepted beat, latch L and seq and check the header.
  - Header error if the magic mismatches, L<8 or L>MAX.
  - If L is legal, a sequence error is raised when seq_lock=1 and seq != exp_seq.
  - A good header sets seq_lock (whether or not the sequence check passed), and exp_seq becomes seq+1, wrapping at 2^32.
  - tlast on the header beat: L==8 with tkeep=FF is a good frame; any other case is a length error. Either way, stay in HDR.
  - With no tlast, go to DATA with beat index k=1.
  - After a header error, payload and length checks are suppressed until tlast; the frame still counts as errored.
- DATA: check each accepted beat at index k; k increments per beat and saturates at 16'hFFFF.
  - Payload error on any mismatch in an enabled byte.
  - Length error if tlast arrives at k != N-1, if k reaches N without tlast (flag once), or if tkeep is wrong.
  - Return to HDR on tlast.

**Statistics**
- On an accepted tlast while checking, frame_cnt increments.
- If any error occurred in that frame, err_frame_cnt also increments and last_err_seq takes the latched seq.
- All counters saturate at all-ones.
- err_flags bits set at the beat where the error is detected and stay set until clr_stat or rst.
- clr_stat zeroes the counters, err_flags, seq_lock and last_err_seq.
  - It wins over a same-cycle update.
  - It does not change the state or in_frame.

**Backpressure**
- A 16-bit Fibonacci LFSR with taps 16,14,13,11 is seeded to 16'hACE1 on rst and advances every cycle.
- rx_axis_tready is registered as (!bp_en) | lfsr[0] | lfsr[1], which is about 75% duty when enabled.

## Timing
- Reset values of outputs:
  - rx_axis_tready = 0.
  - All counters, err_flags, seq_lock and last_err_seq = 0.
  - State is IDLE.
- rx_axis_tready reaches 1 on the first cycle after rst deasserts when bp_en=0.
- A beat is accepted only when tvalid && tready.
- The checker tolerates tvalid gaps; idle cycles change no state.
- err_flags assert one cycle after the offending handshake.
- frame_cnt, err_frame_cnt and last_err_seq update one cycle after the tlast handshake.
- byte_cnt updates one cycle after each accepted beat while test_en=1 and the state is not IDLE.
- A frame error detected on the tlast beat is included in that same frame's count update.
- The sequence wraps from 32'hFFFFFFFF to 0 without an error.

## Test plan
- Reset, bp_en=0, test_en=1. Send 3 frames with L=64 and seq 5, 6, 7 → frame_cnt=3, err_frame_cnt=0, byte_cnt=192, err_flags=0, seq_lock=1.
- Send a frame with L=61: 8 beats, last tkeep=8'h1F → no error, byte_cnt+=61. Repeat with last tkeep=8'h3F → err_flags[3], err_frame_cnt=1.
- Send seq 10, 11, 13 → err_flags[1] set, last_err_seq=13. Then send seq 32'hFFFFFFFF followed by 0 → no new error.
- Corrupt byte 2 of beat 3 → err_flags[2]. Send a bad magic 16'hA55B → err_flags[0]; that frame adds nothing further to err_frame_cnt beyond itself.
- Raise test_en mid-frame → the partial frame is ignored and the next full frame is checked and counted. Drop test_en mid-frame → no count update.
- bp_en=1 with 1000 back-to-back frames → tready duty is 70-80%, no errors, frame_cnt=1000. clr_stat coinciding with a tlast → all counters read 0 afterwards.
